// File: rtl/hough_vote_sched.sv
// hough_vote_sched: clears a single-port vote RAM, casts up to four circle-centre votes per edge pixel
// as read-modify-write transactions, and tracks the best-voted centre.
module hough_vote_sched #(
   parameter int IMG_W  = 600,
   parameter int IMG_H  = 400,
   parameter int X_BIAS = 20,
   parameter int Y_BIAS = 40,
   parameter int RADIUS = 20,
   parameter int CNT_W  = 4,
   parameter int ADDR_W = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [9:0]        pix_x,
   input  logic [8:0]        pix_y,
   input  logic [3:0]        pix_val,
   input  logic              pix_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [CNT_W-1:0]  mem_wdata,
   input  logic [CNT_W-1:0]  mem_rdata,
   output logic [9:0]        best_x,
   output logic [8:0]        best_y,
   output logic [CNT_W-1:0]  best_cnt
);
   typedef enum logic [2:0] {IDLE, CLEAR, WAIT_PIX, RD, WR, DONE} state_t;
   localparam logic signed [11:0] R  = 12'(RADIUS);
   localparam logic signed [11:0] XB = 12'(X_BIAS);
   localparam logic signed [11:0] YB = 12'(Y_BIAS);
   localparam logic signed [11:0] GW = 12'(IMG_W);
   localparam logic signed [11:0] GH = 12'(IMG_H);
   localparam logic [9:0] RX = 10'(RADIUS);
   localparam logic [8:0] RY = 9'(RADIUS);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_W * IMG_H - 1);

   state_t            state;
   logic [9:0]        x;
   logic [8:0]        y;
   logic              last;
   logic [1:0]        k;
   logic [ADDR_W:0]   s_cur, s_nxt;
   logic [CNT_W-1:0]  n;

   // {valid, address} of the vote slot sk around pixel (px, py)
   function automatic logic [ADDR_W:0] probe(input logic [9:0] px, input logic [8:0] py, input logic [1:0] sk);
      logic signed [11:0] cx, cy;
      cx = $signed({2'b00, px}) + ((sk == 2'd0) ? -R : (sk == 2'd1) ? R : 12'sd0) - XB;
      cy = $signed({3'b000, py}) + ((sk == 2'd2) ? -R : (sk == 2'd3) ? R : 12'sd0) - YB;
      return {cx >= 12'sd0 && cx < GW && cy >= 12'sd0 && cy < GH,
              ADDR_W'(cx) + ADDR_W'(cy) * ADDR_W'(IMG_W)};
   endfunction

   assign s_cur = probe(x, y, k);
   // the slot entered next: slot 0 of the pixel being accepted, otherwise slot k+1
   assign s_nxt = (state == WAIT_PIX) ? probe(pix_x, pix_y, 2'd0) : probe(x, y, k + 2'd1);
   assign n = (&mem_rdata) ? mem_rdata : mem_rdata + 1'b1;
   assign mem_wdata = (state == WR) ? n : '0;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pix_ready <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         best_x    <= '0;
         best_y    <= '0;
         best_cnt  <= '0;
         x         <= '0;
         y         <= '0;
         last      <= 1'b0;
         k         <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state    <= CLEAR;
               busy     <= 1'b1;
               mem_we   <= 1'b1;
               mem_addr <= '0;
               best_x   <= '0;
               best_y   <= '0;
               best_cnt <= '0;
            end
            CLEAR: if (mem_addr == LAST_A) begin
               state     <= WAIT_PIX;
               mem_we    <= 1'b0;
               pix_ready <= 1'b1;
            end else
               mem_addr <= mem_addr + 1'b1;
            WAIT_PIX: if (pix_valid) begin
               x    <= pix_x;
               y    <= pix_y;
               last <= pix_last;
               k    <= 2'd0;
               if (pix_val != 4'd0) begin
                  state     <= RD;
                  pix_ready <= 1'b0;
                  if (s_nxt[ADDR_W]) mem_addr <= s_nxt[ADDR_W-1:0];
               end else if (pix_last) begin
                  state     <= DONE;
                  pix_ready <= 1'b0;
                  done      <= 1'b1;
               end
            end
            RD, WR: if (state == RD && s_cur[ADDR_W]) begin
               state  <= WR;
               mem_we <= 1'b1;
            end else begin
               mem_we <= 1'b0;
               if (state == WR && n > best_cnt) begin
                  best_cnt <= n;
                  best_x   <= (k == 2'd0) ? x - RX : (k == 2'd1) ? x + RX : x;
                  best_y   <= (k == 2'd2) ? y - RY : (k == 2'd3) ? y + RY : y;
               end
               if (k != 2'd3) begin
                  state <= RD;
                  k     <= k + 2'd1;
                  if (s_nxt[ADDR_W]) mem_addr <= s_nxt[ADDR_W-1:0];
               end else if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state     <= WAIT_PIX;
                  pix_ready <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_hough_vote_sched.sv
// tb_hough_vote_sched: directed frames against a RAM model and a write scoreboard, plus a
// 2-bit-counter instance sharing the same stimulus to check saturation.
module tb_hough_vote_sched;
   localparam int W = 8, H = 6, R = 2, AW = 6;

   logic clk = 0, rst = 0, start = 0, pix_valid = 0, pix_last = 0;
   logic [9:0] pix_x = '0;
   logic [8:0] pix_y = '0;
   logic [3:0] pix_val = '0;

   logic busy_a, done_a, rdy_a, we_a, busy_b, done_b, rdy_b, we_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [3:0] wd_a, rd_a, bc_a;
   logic [1:0] wd_b, rd_b, bc_b;
   logic [9:0] bx_a, bx_b;
   logic [8:0] by_a, by_b;
   logic [3:0] ram_a [64];
   logic [1:0] ram_b [64];

   typedef struct {int a; int d;} wr_t;
   wr_t q[$];
   wr_t e_m;
   int n_assert = 0, n_fail = 0;
   int mram[64];
   int mbx, mby, mbc, cyc;

   hough_vote_sched #(.IMG_W(W), .IMG_H(H), .X_BIAS(0), .Y_BIAS(0), .RADIUS(R), .CNT_W(4), .ADDR_W(AW)) dut_a (
      .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
      .pix_valid(pix_valid), .pix_ready(rdy_a), .pix_x(pix_x), .pix_y(pix_y), .pix_val(pix_val), .pix_last(pix_last),
      .mem_addr(addr_a), .mem_we(we_a), .mem_wdata(wd_a), .mem_rdata(rd_a),
      .best_x(bx_a), .best_y(by_a), .best_cnt(bc_a));

   hough_vote_sched #(.IMG_W(W), .IMG_H(H), .X_BIAS(0), .Y_BIAS(0), .RADIUS(R), .CNT_W(2), .ADDR_W(AW)) dut_b (
      .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
      .pix_valid(pix_valid), .pix_ready(rdy_b), .pix_x(pix_x), .pix_y(pix_y), .pix_val(pix_val), .pix_last(pix_last),
      .mem_addr(addr_b), .mem_we(we_b), .mem_wdata(wd_b), .mem_rdata(rd_b),
      .best_x(bx_b), .best_y(by_b), .best_cnt(bc_b));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rd_a <= ram_a[addr_a];
      if (we_a) ram_a[addr_a] <= wd_a;
      rd_b <= ram_b[addr_b];
      if (we_b) ram_b[addr_b] <= wd_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clk)
      if (!rst && we_a) begin
         chk("wr_expected", q.size() > 0, 1);
         if (q.size() > 0) begin
            e_m = q.pop_front();
            chk("wr_addr", addr_a, e_m.a);
            chk("wr_data", wd_a, e_m.d);
         end
      end

   task automatic model_clear();
      for (int a = 0; a < W * H; a++) begin
         q.push_back('{a, 0});
         mram[a] = 0;
      end
      mbx = 0; mby = 0; mbc = 0;
   endtask

   task automatic model_vote(input int px, input int py);
      int cx, cy, a, n;
      for (int s = 0; s < 4; s++) begin
         cx = px + (s == 0 ? -R : s == 1 ? R : 0);
         cy = py + (s == 2 ? -R : s == 3 ? R : 0);
         if (cx >= 0 && cx < W && cy >= 0 && cy < H) begin
            a = cx + cy * W;
            n = (mram[a] == 15) ? 15 : mram[a] + 1;
            q.push_back('{a, n});
            mram[a] = n;
            if (n > mbc) begin mbc = n; mbx = cx; mby = cy; end
         end
      end
   endtask

   task automatic chk_reset(input string tg);
      chk({tg, "_busy"}, busy_a, 0);
      chk({tg, "_done"}, done_a, 0);
      chk({tg, "_ready"}, rdy_a, 0);
      chk({tg, "_we"}, we_a, 0);
      chk({tg, "_addr"}, addr_a, 0);
      chk({tg, "_wdata"}, wd_a, 0);
      chk({tg, "_bx"}, bx_a, 0);
      chk({tg, "_by"}, by_a, 0);
      chk({tg, "_bcnt"}, bc_a, 0);
   endtask

   task automatic do_start();
      int c, wes;
      c = 0; wes = 0;
      chk("idle_busy", busy_a, 0);
      model_clear();
      start = 1;
      @(posedge clk); #1;
      chk("busy_rise", busy_a, 1);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         c++;
         if (c == 5) start = 0;
         if (rdy_a) break;
         if (we_a) wes++;
      end
      start = 0;
      chk("clr_cycles", c, 49);
      chk("clr_writes", wes, 48);
   endtask

   task automatic send(input int px, input int py, input int pv, input logic pl);
      if (pv != 0) model_vote(px, py);
      pix_x = 10'(px); pix_y = 9'(py); pix_val = 4'(pv); pix_last = pl; pix_valid = 1;
      for (int i = 0; i < 200; i++) begin
         if (rdy_a) break;
         @(negedge clk);
      end
      chk("send_ready", rdy_a, 1);
      @(posedge clk); #1;
      pix_valid = 0; pix_last = 0;
   endtask

   task automatic wait_done(output int c);
      c = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         c++;
         if (done_a) break;
      end
      chk("done_seen", done_a, 1);
      chk("done_busy", busy_a, 1);
      chk("done_queue", q.size(), 0);
   endtask

   task automatic after_done();
      @(negedge clk);
      chk("done_pulse", done_a, 0);
      chk("busy_fall", busy_a, 0);
   endtask

   initial begin
      #1 rst = 1;
      #12 chk_reset("rst");
      @(negedge clk);
      rst = 0;
      // single interior pixel: all four slots vote
      do_start();
      send(4, 3, 5, 1);
      wait_done(cyc);
      chk("f1_cycles", cyc, 9);
      chk("f1_bx", bx_a, 2);
      chk("f1_by", by_a, 3);
      chk("f1_bcnt", bc_a, 1);
      after_done();
      chk("f1_hold_bcnt", bc_a, 1);
      // corner pixel: only right and down slots are inside the grid
      do_start();
      send(0, 0, 5, 1);
      wait_done(cyc);
      chk("f2_cycles", cyc, 7);
      chk("f2_bx", bx_a, 2);
      chk("f2_by", by_a, 0);
      after_done();
      // four pixels around (4,3)
      do_start();
      send(2, 3, 1, 0);
      send(6, 3, 1, 0);
      send(4, 1, 1, 0);
      send(4, 5, 1, 1);
      wait_done(cyc);
      chk("f3_bx", bx_a, 4);
      chk("f3_by", by_a, 3);
      chk("f3_bcnt", bc_a, 4);
      chk("f3_ram28", ram_a[28], 4);
      after_done();
      // non-edge pixel then five repeats of (2,3): 2-bit counter saturates
      do_start();
      send(3, 3, 0, 0);
      chk("nonedge_ready", rdy_a, 1);
      for (int i = 0; i < 5; i++) send(2, 3, 1, i == 4);
      wait_done(cyc);
      chk("f4_a_bx", bx_a, 0);
      chk("f4_a_by", by_a, 3);
      chk("f4_a_bcnt", bc_a, 5);
      chk("f4_b_bx", bx_b, 0);
      chk("f4_b_by", by_b, 3);
      chk("f4_b_bcnt", bc_b, 3);
      chk("f4_b_ram24", ram_b[24], 3);
      chk("f4_b_ram28", ram_b[28], 3);
      after_done();
      // non-edge last pixel ends the frame directly
      do_start();
      send(1, 1, 0, 1);
      wait_done(cyc);
      chk("f5_cycles", cyc, 1);
      chk("f5_bcnt", bc_a, 0);
      after_done();
      // reset during a WR cycle
      do_start();
      send(4, 3, 1, 0);
      send(4, 3, 1, 1);
      @(posedge clk); #1;
      chk("pre_rst_we", we_a, 1);
      chk("pre_rst_bcnt", bc_a, 1);
      rst = 1;
      #1;
      q.delete();
      chk_reset("rst_wr");
      @(negedge clk);
      rst = 0;
      do_start();
      chk("post_rst_queue", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hough_vote_sched.md
# hough_vote_sched

Frame-level controller for the circle-Hough voting stage. It sits between the edge-pixel stream and a single-port accumulator RAM. For each edge pixel it casts up to four votes (centre at left/right/up/down by RADIUS) by serialising them as read-modify-write transactions on the one RAM port. It also clears the RAM before each frame and tracks the best-voted centre, which it reports on `done`.

## Interface
- IMG_W, 600, accumulator grid width (cells)
- IMG_H, 400, accumulator grid height (cells)
- X_BIAS, 20, image X of grid column 0
- Y_BIAS, 40, image Y of grid row 0
- RADIUS, 20, circle radius in pixels
- CNT_W, 4, vote counter width (saturating)
- ADDR_W, 18, RAM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin frame; ignored while busy=1
- busy  out  1  high from CLEAR through DONE
- done  out  1  one-cycle pulse when the frame is finished
- pix_valid  in  1  pixel offered
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- pix_x  in  10  image X
- pix_y  in  9  image Y
- pix_val  in  4  edge strength; 0 = non-edge
- pix_last  in  1  marks the final pixel of the frame
- mem_addr  out  ADDR_W  RAM address = cx + cy*IMG_W
- mem_we  out  1  write strobe
- mem_wdata  out  CNT_W  write data
- mem_rdata  in  CNT_W  read data, valid one cycle after address (synchronous read)
- best_x  out  10  image X of best centre
- best_y  out  9  image Y of best centre
- best_cnt  out  CNT_W  vote count at best centre

## Operation
- States: IDLE, CLEAR, WAIT_PIX, RD, WR, DONE.
- IDLE: start=1 → CLEAR, with clr_addr=0 and best_x/best_y/best_cnt cleared to 0.
- CLEAR: each cycle writes 0 to clr_addr (mem_we=1) and increments it. After address IMG_W*IMG_H-1 → WAIT_PIX.
- WAIT_PIX: pix_ready=1. On handshake, latch x, y and last, then:
  - pix_val=0 and last=0 → stay in WAIT_PIX.
  - pix_val=0 and last=1 → DONE.
  - pix_val>0 → RD with slot k=0.
- Slot order: k=0 left (x-R, y), k=1 right (x+R, y), k=2 up (x, y-R), k=3 down (x, y+R).
- Centre coordinates are cx = candX - X_BIAS and cy = candY - Y_BIAS, computed signed, 12 bits. A slot is valid iff 0 ≤ cx < IMG_W and 0 ≤ cy < IMG_H.
- RD:
  - Valid slot: drive mem_addr, mem_we=0 → WR.
  - Invalid slot: no memory access; advance k.
- WR:
  - n = mem_rdata+1, saturating at 2^CNT_W-1.
  - mem_we=1, same address, wdata=n.
  - If n > best_cnt (strict; ties keep the earlier centre), update best_cnt=n, best_x=cx+X_BIAS, best_y=cy+Y_BIAS.
  - Advance k.
- Advancing k: if k<3 → RD with k+1. After k=3: last=1 → DONE, otherwise → WAIT_PIX.
- DONE: done=1 for one cycle → IDLE. best_* hold their values until the next start.
- mem_we=0 in IDLE, WAIT_PIX, RD and DONE.

## Timing
- Reset values: state=IDLE, busy=0, done=0, pix_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, best_x=0, best_y=0, best_cnt=0.
- busy rises the cycle after start is sampled. CLEAR lasts exactly IMG_W*IMG_H cycles.
- Per edge pixel: 4 + (number of valid slots) cycles in RD/WR, plus the WAIT_PIX handshake cycle. Minimum 5 cycles, maximum 9.
- A non-edge pixel costs 1 cycle.
- Read data is used in the WR cycle directly after its RD cycle. No two transactions overlap, so there is no read-after-write hazard.
- rst asserted in any state: outputs return to reset values immediately. RAM contents are undefined afterwards and are cleared by the next start.
- start while busy=1 has no effect. pix_valid outside WAIT_PIX is not accepted.

## Test plan
Bench parameters unless stated: IMG_W=8, IMG_H=6, X_BIAS=0, Y_BIAS=0, RADIUS=2, CNT_W=4.
- Start after reset → 48 writes, addresses 0..47 with data 0. pix_ready rises on cycle 49 after start.
- Single pixel (4,3), val=5, last=1 → writes of 1 at addresses 26, 30, 12, 44 in that order. Then best=(2,3), best_cnt=1, and a done pulse.
- Corner pixel (0,0), last=1 → only address 2 (right) and address 16 (down) are accessed. 6 RD/WR cycles, then done.
- Pixels (2,3), (6,3), (4,1), (4,5), last on the 4th → best=(4,3), best_cnt=4. mem_wdata=4 at address 28.
- CNT_W=2, pixel (2,3) sent 5 times → counts at addresses 24 and 28 saturate at 3 (never wrap to 0). best=(0,3), best_cnt=3.
- rst pulsed during a WR cycle → mem_we=0 and busy=0 immediately, best_*=0. The next start performs a full CLEAR.
